jtframe_inputs: RTL and testbench

Parametrised cabinet-input conditioner for MiSTer game tops. Merges PS/2 keyboard events and N MiSTer joystick words into registered, active-low game inputs. Adds pause toggling, coin pulse stretching, per-player autofire on button 1 and SOCD direction cleaning. It sits between hps_io and the game module, and replaces the ad hoc key/joystick logic in each core's emu top.

---
 rtl/jtframe_inputs_pkg.sv | 88 ++++++++
 rtl/jtframe_ps2_keys.sv | 31 +++
 rtl/jtframe_inputs.sv | 137 +++++++++++++
 tb/tb_jtframe_inputs.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtframe_inputs_pkg.sv
// Shared definitions for jtframe_inputs: key-state indices, scancodes with
// their extended flag, and joy_raw bit positions.
package jtframe_inputs_pkg;

  // Per-player slots mirror the joystick output order: R, L, D, U, B1..B4
  typedef enum logic [4:0] {
    K1_R, K1_L, K1_D, K1_U, K1_B1, K1_B2, K1_B3, K1_B4,
    K2_R, K2_L, K2_D, K2_U, K2_B1, K2_B2, K2_B3, K2_B4,
    K_START1, K_START2, K_COIN1, K_COIN2, K_PAUSE, K_SERVICE
  } key_idx_e;

  localparam int unsigned KEY_NUM  = 22;
  localparam int unsigned KEY_SLOT = 8;

  // {extended, scancode}
  localparam logic [8:0] SC_P1_U  = {1'b1, 8'h75};
  localparam logic [8:0] SC_P1_D  = {1'b1, 8'h72};
  localparam logic [8:0] SC_P1_L  = {1'b1, 8'h6B};
  localparam logic [8:0] SC_P1_R  = {1'b1, 8'h74};
  localparam logic [8:0] SC_P1_B1 = {1'b0, 8'h14};
  localparam logic [8:0] SC_P1_B2 = {1'b0, 8'h11};
  localparam logic [8:0] SC_P1_B3 = {1'b0, 8'h29};
  localparam logic [8:0] SC_P1_B4 = {1'b0, 8'h12};
  localparam logic [8:0] SC_P2_U  = {1'b0, 8'h2D};
  localparam logic [8:0] SC_P2_D  = {1'b0, 8'h2B};
  localparam logic [8:0] SC_P2_L  = {1'b0, 8'h23};
  localparam logic [8:0] SC_P2_R  = {1'b0, 8'h34};
  localparam logic [8:0] SC_P2_B1 = {1'b0, 8'h1C};
  localparam logic [8:0] SC_P2_B2 = {1'b0, 8'h1B};
  localparam logic [8:0] SC_P2_B3 = {1'b0, 8'h15};
  localparam logic [8:0] SC_P2_B4 = {1'b0, 8'h1D};
  localparam logic [8:0] SC_START1  = {1'b0, 8'h16};
  localparam logic [8:0] SC_START2  = {1'b0, 8'h1E};
  localparam logic [8:0] SC_COIN1   = {1'b0, 8'h2E};
  localparam logic [8:0] SC_COIN2   = {1'b0, 8'h36};
  localparam logic [8:0] SC_PAUSE   = {1'b0, 8'h4D};
  localparam logic [8:0] SC_SERVICE = {1'b0, 8'h46};

  typedef struct packed {
    logic     hit;
    key_idx_e idx;
  } key_dec_t;

  function automatic key_dec_t decode_key(input logic [8:0] sc);
    key_dec_t d;
    d.hit = 1'b1;
    d.idx = K1_R;
    case (sc)
      SC_P1_U:    d.idx = K1_U;
      SC_P1_D:    d.idx = K1_D;
      SC_P1_L:    d.idx = K1_L;
      SC_P1_R:    d.idx = K1_R;
      SC_P1_B1:   d.idx = K1_B1;
      SC_P1_B2:   d.idx = K1_B2;
      SC_P1_B3:   d.idx = K1_B3;
      SC_P1_B4:   d.idx = K1_B4;
      SC_P2_U:    d.idx = K2_U;
      SC_P2_D:    d.idx = K2_D;
      SC_P2_L:    d.idx = K2_L;
      SC_P2_R:    d.idx = K2_R;
      SC_P2_B1:   d.idx = K2_B1;
      SC_P2_B2:   d.idx = K2_B2;
      SC_P2_B3:   d.idx = K2_B3;
      SC_P2_B4:   d.idx = K2_B4;
      SC_START1:  d.idx = K_START1;
      SC_START2:  d.idx = K_START2;
      SC_COIN1:   d.idx = K_COIN1;
      SC_COIN2:   d.idx = K_COIN2;
      SC_PAUSE:   d.idx = K_PAUSE;
      SC_SERVICE: d.idx = K_SERVICE;
      default:    d.hit = 1'b0;
    endcase
    return d;
  endfunction

  function automatic int unsigned start_bit(input int unsigned buttons);
    return 4 + buttons;
  endfunction

  function automatic int unsigned coin_bit(input int unsigned buttons);
    return 5 + buttons;
  endfunction

  function automatic int unsigned pause_bit(input int unsigned buttons);
    return 6 + buttons;
  endfunction

endpackage

// File: rtl/jtframe_ps2_keys.sv
// PS/2 event detector and key-state register vector; clear wipes all keys
// while the toggle copy keeps tracking so no stale event fires afterwards.
module jtframe_ps2_keys
  import jtframe_inputs_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic [10:0]        ps2_key,
  output logic [KEY_NUM-1:0] keys
);

  logic     toggle_q;
  key_dec_t dec;

  always_comb dec = decode_key(ps2_key[8:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      toggle_q <= 1'b0;
      keys     <= '0;
    end else begin
      toggle_q <= ps2_key[10];
      if (clear)
        keys <= '0;
      else if ((ps2_key[10] != toggle_q) && dec.hit)
        keys[dec.idx] <= ps2_key[9];
    end
  end

endmodule

// File: rtl/jtframe_inputs.sv
// Cabinet input conditioner: merges keyboard and joystick words into
// registered active-low game inputs with SOCD, autofire, coin stretch, pause.
module jtframe_inputs
  import jtframe_inputs_pkg::*;
#(
  parameter int unsigned PLAYERS      = 2,
  parameter int unsigned BUTTONS      = 2,
  parameter int unsigned COIN_CYCLES  = 400000,
  parameter int unsigned AUTOFIRE_DIV = 1333333,
  parameter int unsigned SOCD         = 1
)(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         soft_rst,
  input  logic                         downloading,
  input  logic [10:0]                  ps2_key,
  input  logic [16*PLAYERS-1:0]        joy_raw,
  input  logic [PLAYERS-1:0]           autofire_en,
  output logic [(4+BUTTONS)*PLAYERS-1:0] joystick_n,
  output logic [PLAYERS-1:0]           start_n,
  output logic [PLAYERS-1:0]           coin_n,
  output logic                         service_n,
  output logic                         pause
);

  localparam int unsigned JW = 4 + BUTTONS;
  localparam int unsigned KB = (BUTTONS < 4) ? BUTTONS : 4;
  localparam int unsigned CW = (COIN_CYCLES > 0) ? $clog2(COIN_CYCLES + 1) : 1;
  localparam int unsigned AW = (AUTOFIRE_DIV > 1) ? $clog2(AUTOFIRE_DIV) : 1;
  localparam logic [CW-1:0] COIN_LOAD = CW'(COIN_CYCLES);
  localparam logic [AW-1:0] AF_LAST   = AW'((AUTOFIRE_DIV > 0) ? AUTOFIRE_DIV - 1 : 0);

  logic [KEY_NUM-1:0]           keys;
  logic [PLAYERS-1:0][JW-1:0]   ctl;
  logic [PLAYERS-1:0]           start_m, coin_m, coin_prev;
  logic [PLAYERS-1:0][CW-1:0]   coin_cnt, coin_nxt;
  logic                         pause_m, pause_prev;
  logic [AW-1:0]                af_cnt;
  logic                         af_phase;
  logic                         unused_bits;

  assign unused_bits = ^{keys, joy_raw};

  jtframe_ps2_keys u_keys (
    .clk     (clk),
    .rst     (rst),
    .clear   (downloading),
    .ps2_key (ps2_key),
    .keys    (keys)
  );

  // Merge, then SOCD clean, then autofire gating on button 1
  always_comb begin
    ctl     = '0;
    start_m = '0;
    coin_m  = '0;
    pause_m = keys[K_PAUSE];
    for (int unsigned p = 0; p < PLAYERS; p++) begin
      ctl[p]     = joy_raw[p*16 +: JW];
      start_m[p] = joy_raw[p*16 + start_bit(BUTTONS)];
      coin_m[p]  = joy_raw[p*16 + coin_bit(BUTTONS)];
      pause_m    = pause_m | joy_raw[p*16 + pause_bit(BUTTONS)];
      if (p < 2) begin
        for (int unsigned j = 0; j < 4 + KB; j++)
          ctl[p][j] = ctl[p][j] | keys[p*KEY_SLOT + j];
        start_m[p] = start_m[p] | keys[int'(K_START1) + p];
        coin_m[p]  = coin_m[p]  | keys[int'(K_COIN1) + p];
      end
      if (SOCD != 0) begin
        if (ctl[p][3] && ctl[p][2]) ctl[p][3:2] = 2'b00;
        if (ctl[p][1] && ctl[p][0]) ctl[p][1:0] = 2'b00;
      end
      if (autofire_en[p]) ctl[p][4] = ctl[p][4] & af_phase;
    end
  end

  always_comb begin
    coin_nxt = '0;
    for (int unsigned p = 0; p < PLAYERS; p++) begin
      if (soft_rst || downloading)
        coin_nxt[p] = '0;
      else if (coin_m[p] && !coin_prev[p])
        coin_nxt[p] = COIN_LOAD;
      else if (coin_cnt[p] != '0)
        coin_nxt[p] = coin_cnt[p] - CW'(1);
      else
        coin_nxt[p] = coin_cnt[p];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      af_cnt   <= '0;
      af_phase <= 1'b0;
    end else if (af_cnt == AF_LAST) begin
      af_cnt   <= '0;
      af_phase <= ~af_phase;
    end else begin
      af_cnt <= af_cnt + AW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coin_cnt   <= '0;
      coin_prev  <= '0;
      pause_prev <= 1'b0;
      pause      <= 1'b0;
    end else begin
      coin_cnt   <= coin_nxt;
      coin_prev  <= coin_m;
      pause_prev <= pause_m;
      if (soft_rst || downloading)
        pause <= 1'b0;
      else if (pause_m && !pause_prev)
        pause <= ~pause;
    end
  end

  // coin_n uses the next count so the low time is exactly COIN_CYCLES clocks
  always_ff @(posedge clk or posedge rst) begin
    if (rst || downloading) begin
      joystick_n <= '1;
      start_n    <= '1;
      coin_n     <= '1;
      service_n  <= 1'b1;
    end else begin
      for (int unsigned p = 0; p < PLAYERS; p++) begin
        joystick_n[p*JW +: JW] <= ~ctl[p];
        start_n[p]             <= ~start_m[p];
        coin_n[p]              <= ~(coin_m[p] | (coin_nxt[p] != '0));
      end
      service_n <= ~keys[K_SERVICE];
    end
  end

endmodule

// File: tb/tb_jtframe_inputs.sv
// Bench for jtframe_inputs: directed test-plan steps plus randomized traffic
// checked every cycle against a behavioural model of the input rules.
module tb_jtframe_inputs;

  localparam int P    = 2;
  localparam int B    = 2;
  localparam int JW   = 4 + B;
  localparam int COIN = 10;
  localparam int DIV  = 4;

  logic          clk = 1'b0;
  logic          rst, soft_rst, downloading;
  logic [10:0]   ps2_key;
  logic [31:0]   joy_raw;
  logic [1:0]    autofire_en;
  logic [11:0]   joystick_n;
  logic [1:0]    start_n, coin_n;
  logic          service_n, pause;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  jtframe_inputs #(
    .PLAYERS      (P),
    .BUTTONS      (B),
    .COIN_CYCLES  (COIN),
    .AUTOFIRE_DIV (DIV),
    .SOCD         (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .soft_rst    (soft_rst),
    .downloading (downloading),
    .ps2_key     (ps2_key),
    .joy_raw     (joy_raw),
    .autofire_en (autofire_en),
    .joystick_n  (joystick_n),
    .start_n     (start_n),
    .coin_n      (coin_n),
    .service_n   (service_n),
    .pause       (pause)
  );

  // Keyboard layout as {ext, code}; direction order R, L, D, U
  int kdir[2][4]  = '{'{'h174, 'h16B, 'h172, 'h175}, '{'h034, 'h023, 'h02B, 'h02D}};
  int kbtn[2][4]  = '{'{'h014, 'h011, 'h029, 'h012}, '{'h01C, 'h01B, 'h015, 'h01D}};
  int kstart[2]   = '{'h016, 'h01E};
  int kcoin[2]    = '{'h02E, 'h036};
  int codes[16]   = '{'h175, 'h172, 'h16B, 'h174, 'h014, 'h011, 'h02D, 'h034,
                      'h01C, 'h016, 'h02E, 'h036, 'h04D, 'h046, 'h075, 'h114};

  // Behavioural model state
  bit          kd[int];
  bit          m_tog, m_pause, m_psrc_prev;
  int          m_cyc;
  int          coin_until[2];
  bit          coin_prev[2];
  logic [11:0] e_joy;
  logic [1:0]  e_start, e_coin;
  logic        e_serv;

  function automatic bit key_down(int sc);
    return kd.exists(sc) ? kd[sc] : 1'b0;
  endfunction

  task automatic model_reset();
    kd.delete();
    m_tog = 0; m_pause = 0; m_psrc_prev = 0; m_cyc = 0;
    coin_until = '{0, 0};
    coin_prev  = '{0, 0};
    e_joy = '1; e_start = '1; e_coin = '1; e_serv = 1'b1;
  endtask

  task automatic model_edge();
    bit phase, psrc, u, d, l, r, st, cn;
    bit [15:0]  w;
    bit [B-1:0] btn;
    phase = ((m_cyc / DIV) % 2) == 1;
    psrc  = key_down('h04D);
    for (int p = 0; p < P; p++) begin
      w  = joy_raw[p*16 +: 16];
      r  = w[0] | key_down(kdir[p][0]);
      l  = w[1] | key_down(kdir[p][1]);
      d  = w[2] | key_down(kdir[p][2]);
      u  = w[3] | key_down(kdir[p][3]);
      for (int j = 0; j < B; j++) btn[j] = w[4+j] | key_down(kbtn[p][j]);
      st = w[4+B] | key_down(kstart[p]);
      cn = w[5+B] | key_down(kcoin[p]);
      psrc = psrc | w[6+B];
      if (u && d) begin u = 0; d = 0; end
      if (l && r) begin l = 0; r = 0; end
      if (autofire_en[p]) btn[0] = btn[0] & phase;
      if (soft_rst || downloading) coin_until[p] = 0;
      else if (cn && !coin_prev[p]) coin_until[p] = m_cyc + COIN;
      coin_prev[p] = cn;
      e_coin[p]  = !(cn || (m_cyc < coin_until[p]));
      e_start[p] = !st;
      e_joy[p*JW +: JW] = ~{btn, u, d, l, r};
    end
    e_serv = !key_down('h046);
    if (downloading) begin
      e_joy = '1; e_start = '1; e_coin = '1; e_serv = 1'b1;
    end
    if (soft_rst || downloading) m_pause = 0;
    else if (psrc && !m_psrc_prev) m_pause = !m_pause;
    m_psrc_prev = psrc;
    if (downloading) kd.delete();
    else if (ps2_key[10] != m_tog) kd[int'(ps2_key[8:0])] = ps2_key[9];
    m_tog = ps2_key[10];
    m_cyc++;
  endtask

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("joystick_n", 32'(joystick_n), 32'(e_joy));
    chk("start_n",    32'(start_n),    32'(e_start));
    chk("coin_n",     32'(coin_n),     32'(e_coin));
    chk("service_n",  32'(service_n),  32'(e_serv));
    chk("pause",      32'(pause),      32'(m_pause));
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      if (!rst) model_edge();
      @(negedge clk);
      check_all();
    end
  endtask

  task automatic send_key(bit pressed, bit ext, logic [7:0] code);
    ps2_key = {~ps2_key[10], pressed, ext, code};
  endtask

  int lows, changes;
  logic prev_s;

  initial begin
    rst = 1; soft_rst = 0; downloading = 0;
    ps2_key = '0; joy_raw = '0; autofire_en = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_joy",   32'(joystick_n), 32'hFFF);
    chk("rst_start", 32'(start_n),    32'h3);
    chk("rst_coin",  32'(coin_n),     32'h3);
    chk("rst_serv",  32'(service_n),  32'h1);
    chk("rst_pause", 32'(pause),      32'h0);
    rst = 0;
    step(2);

    // Extended arrow: two clocks to output; non-extended 75 ignored
    send_key(1, 1, 8'h75);
    step(1);
    chk("ext_up_lat1", 32'(joystick_n[3]), 32'h1);
    step(1);
    chk("ext_up_lat2", 32'(joystick_n[3]), 32'h0);
    send_key(0, 1, 8'h75);
    step(2);
    chk("ext_up_rel", 32'(joystick_n[3]), 32'h1);
    send_key(1, 0, 8'h75);
    step(2);
    chk("kp8_ignored", 32'(joystick_n[3]), 32'h1);
    send_key(0, 0, 8'h75);
    step(2);

    // SOCD
    joy_raw = 32'h0000_000C;
    step(1);
    chk("socd_ud", 32'(joystick_n[3:2]), 32'h3);
    joy_raw = 32'h0000_0008;
    step(1);
    chk("socd_u", 32'(joystick_n[3:2]), 32'h1);
    joy_raw = '0;
    step(1);

    // Coin stretch: one-clock pulse holds coin_n low for COIN clocks
    joy_raw[5+B] = 1'b1;
    step(1);
    joy_raw[5+B] = 1'b0;
    chk("coin_first", 32'(coin_n[0]), 32'h0);
    for (int i = 0; i < COIN - 1; i++) begin
      step(1);
      chk("coin_hold", 32'(coin_n[0]), 32'h0);
    end
    step(1);
    chk("coin_end", 32'(coin_n[0]), 32'h1);
    step(2);
    // Reload while the count is 3
    joy_raw[5+B] = 1'b1;
    step(1);
    joy_raw[5+B] = 1'b0;
    step(7);
    joy_raw[5+B] = 1'b1;
    step(1);
    joy_raw[5+B] = 1'b0;
    for (int i = 0; i < COIN - 1; i++) begin
      step(1);
      chk("coin_reload", 32'(coin_n[0]), 32'h0);
    end
    step(1);
    chk("coin_reload_end", 32'(coin_n[0]), 32'h1);

    // Autofire: square wave, 4 low / 4 high
    joy_raw = 32'h0000_0010;
    autofire_en = 2'b01;
    step(1);
    prev_s = joystick_n[4];
    lows = 0; changes = 0;
    repeat (8) begin
      step(1);
      if (joystick_n[4] == 1'b0) lows++;
      if (joystick_n[4] != prev_s) changes++;
      prev_s = joystick_n[4];
    end
    chk("af_duty", 32'(lows), 32'd4);
    chk("af_edges", 32'(changes), 32'd2);
    autofire_en = 2'b00;
    step(1);
    lows = 0;
    repeat (8) begin
      step(1);
      if (joystick_n[4] == 1'b0) lows++;
    end
    chk("af_off", 32'(lows), 32'd8);
    joy_raw = '0;
    step(1);

    // Pause toggling
    send_key(1, 0, 8'h4D);
    step(2);
    chk("pause_on", 32'(pause), 32'h1);
    send_key(0, 0, 8'h4D);
    step(2);
    send_key(1, 0, 8'h4D);
    step(2);
    chk("pause_off", 32'(pause), 32'h0);
    send_key(0, 0, 8'h4D);
    step(2);
    soft_rst = 1;
    joy_raw[6+B] = 1'b1;
    step(1);
    chk("pause_softrst", 32'(pause), 32'h0);
    soft_rst = 0;
    step(1);
    chk("pause_held", 32'(pause), 32'h0);
    joy_raw = '0;
    step(1);

    // Download with keys held
    joy_raw[6+B] = 1'b1;
    step(1);
    chk("pause_joy", 32'(pause), 32'h1);
    joy_raw = 32'h0000_0008;
    send_key(1, 0, 8'h14);
    step(2);
    chk("pre_dl_joy", 32'(joystick_n[5:0]), 32'h27);
    downloading = 1;
    step(1);
    chk("dl_joy", 32'(joystick_n), 32'hFFF);
    chk("dl_pause", 32'(pause), 32'h0);
    send_key(1, 1, 8'h75);
    step(2);
    chk("dl_event", 32'(joystick_n), 32'hFFF);
    downloading = 0;
    joy_raw = '0;
    step(2);
    chk("post_dl", 32'(joystick_n), 32'hFFF);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 3) == 0)
        joy_raw = $urandom & $urandom & $urandom;
      if ($urandom_range(0, 2) == 0)
        ps2_key = {~ps2_key[10], 1'($urandom_range(0, 1)), 9'(codes[$urandom_range(0, 15)])};
      if ($urandom_range(0, 15) == 0)
        autofire_en = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 59) == 0)
        downloading = ~downloading;
      soft_rst = ($urandom_range(0, 39) == 0);
      step(1);
    end
    downloading = 0; soft_rst = 0; joy_raw = '0;
    step(2);

    // Asynchronous reset mid-operation
    soft_rst = 1;
    step(1);
    soft_rst = 0;
    joy_raw[5+B] = 1'b1;
    joy_raw[6+B] = 1'b1;
    step(1);
    joy_raw = '0;
    step(2);
    chk("pre_rst_pause", 32'(pause), 32'h1);
    chk("pre_rst_coin", 32'(coin_n[0]), 32'h0);
    #2 rst = 1;
    #1;
    chk("arst_joy",   32'(joystick_n), 32'hFFF);
    chk("arst_start", 32'(start_n),    32'h3);
    chk("arst_coin",  32'(coin_n),     32'h3);
    chk("arst_serv",  32'(service_n),  32'h1);
    chk("arst_pause", 32'(pause),      32'h0);
    @(negedge clk);
    rst = 0;
    model_reset();
    step(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
